// File: rtl/digit_sequencer_if.sv
// Pin-side bundle between the board inputs, the digit sequencer and the 7-segment decoder.
interface digit_sequencer_if;
    localparam int unsigned DIGIT_W = 4;

    logic               ena;
    logic               run_btn;
    logic               dir;
    logic               clr;
    logic [DIGIT_W-1:0] counter;
    logic               tick;
    logic               running;

    modport master (output ena, run_btn, dir, clr, input counter, tick, running);
    modport slave  (input ena, run_btn, dir, clr, output counter, tick, running);
endinterface

// File: rtl/digit_sequencer.sv
// Digit sequencer: debounced run/pause button, prescaled wrapping 0..MAX_VAL digit counter.
// Optional macro SEQ_PINGPONG_EN: bounce between 0 and MAX_VAL instead of wrapping,
// with the direction latched from dir when a run starts.
module digit_sequencer #(
    parameter int unsigned PRESCALE   = 4,
    parameter int unsigned PRESCALE_W = 24,
    parameter int unsigned MAX_VAL    = 7,
    parameter int unsigned DEBOUNCE   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    digit_sequencer_if.slave bus
);
    localparam int unsigned               DIGIT_W       = 4;
    localparam int unsigned               DB_W          = $clog2(DEBOUNCE + 1);
    localparam logic [DIGIT_W-1:0]        MAX_DIGIT     = DIGIT_W'(MAX_VAL);
    localparam logic [PRESCALE_W-1:0]     PRESCALE_LAST = PRESCALE_W'(PRESCALE - 1);
    localparam logic [DB_W-1:0]           DB_LAST       = DB_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            sync_q;
    logic                  stable_q;
    logic                  stable_prev_q;
    logic [DB_W-1:0]       db_cnt_q;
    logic                  press_c;
    logic                  step_c;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [DIGIT_W-1:0]    counter_q, counter_d;
    logic                  tick_q, tick_d;
    logic                  running_q;
`ifdef SEQ_PINGPONG_EN
    logic                  up_q, up_d;
`endif

    // Two-flop synchronizer; keeps sampling even while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], bus.run_btn};
        end
    end

    // Debounce: accept a new level after DEBOUNCE consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            db_cnt_q      <= '0;
        end else if (bus.ena) begin
            stable_prev_q <= stable_q;
            if (sync_q[1] == stable_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                stable_q <= sync_q[1];
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end
        end
    end

    // One-cycle press on a rising accepted level; held off while disabled.
    assign press_c = bus.ena & stable_q & ~stable_prev_q;

    // Next state, prescaler and digit; priority clr > press > step.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        counter_d = counter_q;
        tick_d    = 1'b0;
        step_c    = 1'b0;
`ifdef SEQ_PINGPONG_EN
        up_d      = up_q;
`endif
        if (bus.ena) begin
            if (bus.clr) begin
                state_d   = IDLE;
                presc_d   = '0;
                counter_d = '0;
`ifdef SEQ_PINGPONG_EN
                up_d      = 1'b1;
`endif
            end else begin
                if (state_q == RUN) begin
                    if (presc_q == PRESCALE_LAST) begin
                        presc_d = '0;
                        step_c  = 1'b1;
                    end else begin
                        presc_d = presc_q + PRESCALE_W'(1);
                    end
                end
                if (press_c) begin
                    unique case (state_q)
                        IDLE: begin
                            state_d = RUN;
`ifdef SEQ_PINGPONG_EN
                            up_d    = bus.dir;
`endif
                        end
                        RUN:     state_d = PAUSE;
                        PAUSE:   state_d = RUN;
                        default: state_d = IDLE;
                    endcase
                end else if (step_c) begin
                    tick_d = 1'b1;
`ifdef SEQ_PINGPONG_EN
                    if (up_q) begin
                        if (counter_q == MAX_DIGIT) begin
                            counter_d = MAX_DIGIT - DIGIT_W'(1);
                            up_d      = 1'b0;
                        end else begin
                            counter_d = counter_q + DIGIT_W'(1);
                        end
                    end else begin
                        if (counter_q == '0) begin
                            counter_d = DIGIT_W'(1);
                            up_d      = 1'b1;
                        end else begin
                            counter_d = counter_q - DIGIT_W'(1);
                        end
                    end
`else
                    if (bus.dir) begin
                        counter_d = (counter_q == MAX_DIGIT) ? '0 : counter_q + DIGIT_W'(1);
                    end else begin
                        counter_d = (counter_q == '0) ? MAX_DIGIT : counter_q - DIGIT_W'(1);
                    end
`endif
                end
            end
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            counter_q <= '0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
`ifdef SEQ_PINGPONG_EN
            up_q      <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            counter_q <= counter_d;
            tick_q    <= tick_d;
            running_q <= (state_d == RUN);
`ifdef SEQ_PINGPONG_EN
            up_q      <= up_d;
`endif
        end
    end

    assign bus.counter = counter_q;
    assign bus.tick    = tick_q;
    assign bus.running = running_q;

endmodule

// File: tb/tb_digit_sequencer.sv
// Bench for digit_sequencer: directed scenarios with literal expectations plus a
// randomized run compared each cycle against a behavioural model.
`timescale 1ns/1ps
module tb_digit_sequencer;
    localparam int unsigned PRESCALE   = 4;
    localparam int unsigned PRESCALE_W = 24;
    localparam int unsigned MAX_VAL    = 7;
    localparam int unsigned DEBOUNCE   = 3;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 0;

    digit_sequencer_if bus();

    digit_sequencer #(
        .PRESCALE   (PRESCALE),
        .PRESCALE_W (PRESCALE_W),
        .MAX_VAL    (MAX_VAL),
        .DEBOUNCE   (DEBOUNCE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 run, 2 pause; phase counts enabled run cycles.
    bit m_s1 = 0, m_s2 = 0, m_stable = 0, m_press_pend = 0;
    bit m_hist[$];
    int m_mode = 0, m_phase = 0, m_cnt = 0;
    bit m_tick = 0, m_up = 1;
    bit m_press, m_step, m_all_diff, m_samp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_stable = 0; m_press_pend = 0;
            m_hist.delete();
            m_mode = 0; m_phase = 0; m_cnt = 0; m_tick = 0; m_up = 1;
        end else begin
            m_samp = m_s2;
            m_s2   = m_s1;
            m_s1   = bus.run_btn;
            m_tick = 0;
            if (bus.ena) begin
                m_press      = m_press_pend;
                m_press_pend = 0;
                m_hist.push_back(m_samp);
                if (m_hist.size() > DEBOUNCE) void'(m_hist.pop_front());
                m_all_diff = (m_hist.size() == DEBOUNCE);
                foreach (m_hist[i]) if (m_hist[i] == m_stable) m_all_diff = 0;
                if (m_all_diff) begin
                    m_stable     = m_samp;
                    m_press_pend = m_samp;
                end
                if (bus.clr) begin
                    m_mode = 0; m_phase = 0; m_cnt = 0; m_up = 1;
                end else begin
                    m_step = 0;
                    if (m_mode == 1) begin
                        m_phase = (m_phase + 1) % PRESCALE;
                        m_step  = (m_phase == 0);
                    end
                    if (m_press) begin
                        if (m_mode == 0) m_up = bus.dir;
                        m_mode = (m_mode == 1) ? 2 : 1;
                    end else if (m_step) begin
                        m_tick = 1;
`ifdef SEQ_PINGPONG_EN
                        if (m_up) begin
                            if (m_cnt == MAX_VAL) begin m_cnt = MAX_VAL - 1; m_up = 0; end
                            else m_cnt = m_cnt + 1;
                        end else begin
                            if (m_cnt == 0) begin m_cnt = 1; m_up = 1; end
                            else m_cnt = m_cnt - 1;
                        end
`else
                        if (bus.dir) m_cnt = (m_cnt + 1) % (MAX_VAL + 1);
                        else         m_cnt = (m_cnt + MAX_VAL) % (MAX_VAL + 1);
`endif
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_counter", int'(bus.counter), m_cnt);
            check("model_tick", int'(bus.tick), int'(m_tick));
            check("model_running", int'(bus.running), (m_mode == 1) ? 1 : 0);
        end
    end

    task automatic wait_tick(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = bus.tick;
        end
        check(name, int'(seen), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  bad;
        int  edges;
        int  hold;
        int  ena_off;
        bit  found;
        bit  seen;

        rst_n       = 1'b0;
        bus.ena     = 1'b1;
        bus.run_btn = 1'b0;
        bus.dir     = 1'b1;
        bus.clr     = 1'b0;
        #1;
        cmp_en = 1;
        check("rst_counter", int'(bus.counter), 0);
        check("rst_tick", int'(bus.tick), 0);
        check("rst_running", int'(bus.running), 0);
        #22 rst_n = 1'b1;

        // Idle with no press: outputs stay at reset values.
        repeat (20) @(negedge clk);
        check("idle_counter", int'(bus.counter), 0);
        check("idle_running", int'(bus.running), 0);

        // Start: raw rise becomes RUN on the sixth edge.
        bus.run_btn = 1'b1;
        repeat (5) @(negedge clk);
        check("start_edge5_running", int'(bus.running), 0);
        @(negedge clk);
        check("start_edge6_running", int'(bus.running), 1);
        repeat (2) @(negedge clk);
        bus.run_btn = 1'b0;
        @(negedge clk);
        check("first_step_edge9_counter", int'(bus.counter), 0);
        @(negedge clk);
        check("first_step_edge10_counter", int'(bus.counter), 1);
        check("first_step_edge10_tick", int'(bus.tick), 1);
        n = 0;
        repeat (32) begin
            @(negedge clk);
            if (bus.tick) n++;
        end
        check("ticks_per_32", n, 8);
        check("counter_after_wrap", int'(bus.counter), 1);

        // Count down through the wrap.
        bus.dir = 1'b0;
        wait_tick("down_tick0");
        check("down_0", int'(bus.counter), 0);
        wait_tick("down_tick7");
        check("down_7", int'(bus.counter), 7);
        wait_tick("down_tick6");
        check("down_6", int'(bus.counter), 6);
        wait_tick("down_tick5");
        check("down_5", int'(bus.counter), 5);

        // Short glitch is rejected.
        bus.run_btn = 1'b1;
        repeat (2) @(negedge clk);
        bus.run_btn = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_running", int'(bus.running), 1);

        // Pause at 5, hold, then resume with the kept prescaler phase.
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            wait_tick("seek6_tick");
            found = (bus.counter == 4'd6);
        end
        check("seek6_found", int'(found), 1);
        bus.run_btn = 1'b1;
        repeat (6) @(negedge clk);
        check("pause_running", int'(bus.running), 0);
        check("pause_counter", int'(bus.counter), 5);
        repeat (2) @(negedge clk);
        bus.run_btn = 1'b0;
        n = 0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.tick) n++;
            if (bus.counter != 4'd5) bad++;
        end
        check("pause_ticks", n, 0);
        check("pause_hold_bad", bad, 0);
        bus.run_btn = 1'b1;
        repeat (6) @(negedge clk);
        check("resume_running", int'(bus.running), 1);
        @(negedge clk);
        check("resume_r1_counter", int'(bus.counter), 5);
        check("resume_r1_tick", int'(bus.tick), 0);
        @(negedge clk);
        check("resume_r2_counter", int'(bus.counter), 4);
        check("resume_r2_tick", int'(bus.tick), 1);
        bus.run_btn = 1'b0;

        // clr wins over a coincident press and step.
        repeat (2) @(negedge clk);
        bus.run_btn = 1'b1;
        repeat (5) @(negedge clk);
        check("pre_clr_counter", int'(bus.counter), 3);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        check("clr_counter", int'(bus.counter), 0);
        check("clr_running", int'(bus.running), 0);
        check("clr_tick", int'(bus.tick), 0);
        repeat (2) @(negedge clk);
        bus.run_btn = 1'b0;
        repeat (20) @(negedge clk);
        check("post_clr_running", int'(bus.running), 0);

        // ena low freezes everything in RUN.
        bus.dir = 1'b1;
        bus.run_btn = 1'b1;
        repeat (6) @(negedge clk);
        check("restart_running", int'(bus.running), 1);
        repeat (2) @(negedge clk);
        bus.run_btn = 1'b0;
        wait_tick("ena_tick1");
        wait_tick("ena_tick2");
        check("pre_freeze_counter", int'(bus.counter), 2);
        bus.ena = 1'b0;
        n = 0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.tick) n++;
            if (bus.counter != 4'd2) bad++;
        end
        check("freeze_ticks", n, 0);
        check("freeze_counter_bad", bad, 0);
        bus.ena = 1'b1;
        edges = 0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            edges++;
            seen = bus.tick;
        end
        check("unfreeze_latency", edges, 4);
        check("unfreeze_counter", int'(bus.counter), 3);

        // Randomized traffic against the model.
        hold = 0;
        ena_off = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (!rst_n) rst_n = 1'b1;
            if (hold == 0) begin
                bus.run_btn = ~bus.run_btn;
                hold = bus.run_btn ? int'($urandom_range(1, 10)) : int'($urandom_range(5, 60));
            end else begin
                hold--;
            end
            if ($urandom_range(0, 31) == 0) bus.dir = ~bus.dir;
            bus.clr = ($urandom_range(0, 199) == 0);
            if (ena_off == 0 && $urandom_range(0, 63) == 0) ena_off = int'($urandom_range(1, 12));
            bus.ena = (ena_off == 0);
            if (ena_off > 0) ena_off--;
            if (cyc > 0 && $urandom_range(0, 1499) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                check("async_rst_counter", int'(bus.counter), 0);
                check("async_rst_tick", int'(bus.tick), 0);
                check("async_rst_running", int'(bus.running), 0);
            end
        end
        rst_n = 1'b1;
        bus.clr = 1'b0;
        bus.ena = 1'b1;
        repeat (5) @(negedge clk);
        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
